// File: rtl/gmii_mac_tx.sv
// gmii_mac_tx: turns a valid/ready byte stream into GMII frames (preamble, SFD, payload, FCS, IFG).
// Define GMII_MAC_TX_PAD_EN to zero-pad short frames to p_MIN_PAYLOAD bytes before the FCS.
module gmii_mac_tx #(
    parameter int p_IFG_BYTES   = 12,
    parameter int p_MIN_PAYLOAD = 60
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    input  logic       i_tx_last,
    input  logic       i_tx_user,
    output logic       o_tx_ready,
    output logic       o_gmii_tx_en,
    output logic       o_gmii_tx_err,
    output logic [7:0] o_gmii_tx_d,
    output logic       o_busy,
    output logic       o_frame_sent,
    output logic       o_underrun
);

    if (p_IFG_BYTES < 1 || p_IFG_BYTES > 255) begin : g_ifg_range
        $error("p_IFG_BYTES must be in 1..255");
    end
    if (p_MIN_PAYLOAD < 1 || p_MIN_PAYLOAD > 255) begin : g_min_range
        $error("p_MIN_PAYLOAD must be in 1..255");
    end

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PREAMBLE = 4'd1;
    localparam logic [3:0] S_SFD      = 4'd2;
    localparam logic [3:0] S_DATA     = 4'd3;
    localparam logic [3:0] S_FCS      = 4'd4;
    localparam logic [3:0] S_IFG      = 4'd5;
    localparam logic [3:0] S_ABORT    = 4'd6;
    localparam logic [3:0] S_DISCARD  = 4'd7;
`ifdef GMII_MAC_TX_PAD_EN
    localparam logic [3:0] S_PAD      = 4'd8;
    localparam logic [7:0] MIN_LEN    = 8'(p_MIN_PAYLOAD);
`endif
    localparam logic [7:0] IFG_LAST   = 8'(p_IFG_BYTES - 1);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic [3:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] crc_reg, crc_next;
    logic        user_reg, user_next;
    logic        ready_next, en_next, err_next, busy_next, sent_next, underrun_next;
    logic [7:0]  d_next;
    logic [7:0]  byte_cnt_inc;
    logic [31:0] crc_inv;
    logic [1:0]  fcs_sel;
    logic        frame_tail, to_ifg;

    assign byte_cnt_inc = (byte_cnt_reg == 8'hFF) ? 8'hFF : byte_cnt_reg + 8'd1;
    assign crc_inv      = ~crc_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        crc_next      = crc_reg;
        user_next     = user_reg;
        ready_next    = 1'b0;
        en_next       = 1'b0;
        err_next      = 1'b0;
        d_next        = 8'h00;
        sent_next     = 1'b0;
        underrun_next = 1'b0;
        fcs_sel       = 2'd0;
        frame_tail    = 1'b0;
        to_ifg        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                byte_cnt_next = 8'd0;
                crc_next      = 32'hFFFFFFFF;
                user_next     = 1'b0;
                if (i_tx_valid) begin
                    state_next = S_PREAMBLE;
                    cnt_next   = 8'd1;
                    en_next    = 1'b1;
                    d_next     = 8'h55;
                end
            end
            S_PREAMBLE: begin
                en_next = 1'b1;
                if (cnt_reg == 8'd7) begin
                    state_next = S_SFD;
                    d_next     = 8'hD5;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    d_next   = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                if (o_tx_ready) begin
                    en_next = 1'b1;
                    if (i_tx_valid) begin
                        state_next    = S_DATA;
                        d_next        = i_tx_data;
                        crc_next      = crc_byte(crc_reg, i_tx_data);
                        byte_cnt_next = byte_cnt_inc;
                        ready_next    = !i_tx_last;
                        if (i_tx_last) begin
                            user_next = i_tx_user;
                        end
                    end else begin
                        // Starved mid-frame: one TX_ER cycle poisons the frame on the wire.
                        state_next    = S_ABORT;
                        err_next      = 1'b1;
                        underrun_next = 1'b1;
                    end
                end else begin
                    frame_tail = 1'b1;
                end
            end
`ifdef GMII_MAC_TX_PAD_EN
            S_PAD: begin
                frame_tail = 1'b1;
            end
`endif
            S_FCS: begin
                if (cnt_reg[1:0] == 2'd3) begin
                    to_ifg = 1'b1;
                end else begin
                    fcs_sel  = cnt_reg[1:0] + 2'd1;
                    en_next  = 1'b1;
                    cnt_next = cnt_reg + 8'd1;
                    d_next   = crc_inv[{fcs_sel, 3'b000} +: 8];
                    if (fcs_sel == 2'd3) begin
                        sent_next = 1'b1;
                        err_next  = user_reg;
                    end
                end
            end
            S_ABORT: begin
                state_next = S_DISCARD;
                ready_next = 1'b1;
            end
            S_DISCARD: begin
                if (i_tx_valid && i_tx_last) begin
                    to_ifg = 1'b1;
                end else begin
                    ready_next = 1'b1;
                end
            end
            S_IFG: begin
                if (cnt_reg == IFG_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Last payload byte is on the wire: pad out or launch FCS byte 0 with no gap.
        if (frame_tail) begin
            en_next = 1'b1;
`ifdef GMII_MAC_TX_PAD_EN
            if (byte_cnt_reg < MIN_LEN) begin
                state_next    = S_PAD;
                d_next        = 8'h00;
                crc_next      = crc_byte(crc_reg, 8'h00);
                byte_cnt_next = byte_cnt_inc;
            end else begin
                state_next = S_FCS;
                cnt_next   = 8'd0;
                d_next     = crc_inv[7:0];
            end
`else
            state_next = S_FCS;
            cnt_next   = 8'd0;
            d_next     = crc_inv[7:0];
`endif
        end

        // The IDLE cycle that samples valid is itself the last gap cycle.
        if (to_ifg) begin
            if (p_IFG_BYTES > 1) begin
                state_next = S_IFG;
                cnt_next   = 8'd1;
            end else begin
                state_next = S_IDLE;
            end
        end

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 8'd0;
            byte_cnt_reg  <= 8'd0;
            crc_reg       <= 32'hFFFFFFFF;
            user_reg      <= 1'b0;
            o_tx_ready    <= 1'b0;
            o_gmii_tx_en  <= 1'b0;
            o_gmii_tx_err <= 1'b0;
            o_gmii_tx_d   <= 8'h00;
            o_busy        <= 1'b0;
            o_frame_sent  <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            crc_reg       <= crc_next;
            user_reg      <= user_next;
            o_tx_ready    <= ready_next;
            o_gmii_tx_en  <= en_next;
            o_gmii_tx_err <= err_next;
            o_gmii_tx_d   <= d_next;
            o_busy        <= busy_next;
            o_frame_sent  <= sent_next;
            o_underrun    <= underrun_next;
        end
    end

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Self-checking bench for gmii_mac_tx: random payloads checked against a table-driven frame model.
`timescale 1ns/1ps
module tb_gmii_mac_tx;
    localparam int IFG = 12;
    localparam int MIN = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_user = 1'b0;
    logic       tx_ready, gmii_en, gmii_err, busy, frame_sent, underrun;
    logic [7:0] gmii_d;

    int checks = 0;
    int failures = 0;

    always #4 clk = ~clk;

    gmii_mac_tx #(.p_IFG_BYTES(IFG), .p_MIN_PAYLOAD(MIN)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .i_tx_last(tx_last), .i_tx_user(tx_user), .o_tx_ready(tx_ready),
        .o_gmii_tx_en(gmii_en), .o_gmii_tx_err(gmii_err), .o_gmii_tx_d(gmii_d),
        .o_busy(busy), .o_frame_sent(frame_sent), .o_underrun(underrun)
    );

    typedef struct packed {
        logic       en;
        logic       err;
        logic [7:0] d;
        logic       sent;
        logic       und;
        logic       rdy;
    } rec_t;

    rec_t cap[$];
    always @(negedge clk) cap.push_back({gmii_en, gmii_err, gmii_d, frame_sent, underrun, tx_ready});

    logic [31:0]  crc_tab [256];
    logic [7:0]   pl_q[$];
    logic [7:0]   exp_q[$];
    int scan, run_start, run_len, bad_bytes, err_cnt, sent_cnt, und_cnt;
    rec_t last_rec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input int n);
        pl_q.delete();
        repeat (n) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Expected wire bytes for one complete frame: preamble, SFD, body (padded if built so), FCS LSB first.
    task automatic build_expected();
        logic [7:0]  body[$];
        logic [31:0] crc;
        logic [7:0]  idx;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        body = pl_q;
`ifdef GMII_MAC_TX_PAD_EN
        while (body.size() < MIN) body.push_back(8'h00);
`endif
        crc = 32'hFFFFFFFF;
        foreach (body[k]) begin
            idx = crc[7:0] ^ body[k];
            crc = crc_tab[idx] ^ (crc >> 8);
            exp_q.push_back(body[k]);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    endtask

    task automatic find_run();
        int i = scan;
        bad_bytes = 0; err_cnt = 0; sent_cnt = 0; und_cnt = 0; run_len = 0;
        last_rec = '0;
        while (i < cap.size() && cap[i].en !== 1'b1) i++;
        run_start = i;
        while (i < cap.size() && cap[i].en === 1'b1) begin
            if (run_len >= exp_q.size() || cap[i].d !== exp_q[run_len]) bad_bytes++;
            if (cap[i].err) err_cnt++;
            if (cap[i].sent) sent_cnt++;
            if (cap[i].und) und_cnt++;
            last_rec = cap[i];
            run_len++;
            i++;
        end
        scan = i;
    endtask

    task automatic check_normal(input string tag, input bit user);
        build_expected();
        find_run();
        check({tag, " en_len"}, run_len, exp_q.size());
        check({tag, " bad_bytes"}, bad_bytes, 0);
        check({tag, " err_cnt"}, err_cnt, 32'(user));
        check({tag, " err_last"}, last_rec.err, user);
        check({tag, " sent_cnt"}, sent_cnt, 1);
        check({tag, " sent_last"}, last_rec.sent, 1);
        check({tag, " und_cnt"}, und_cnt, 0);
    endtask

    task automatic send(input int drop_at, input int rst_at, input bit user, output bit timed_out);
        int n = pl_q.size();
        int idx = 0;
        int guard = 0;
        bit acc;
        bit dropped = 0;
        timed_out = 0;
        tx_valid = 1'b1; tx_data = pl_q[0]; tx_last = (n == 1); tx_user = user && (n == 1);
        while (idx < n) begin
            @(negedge clk);
            acc = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) idx++;
            if (idx == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check("reset outs", {gmii_en, gmii_err, gmii_d, tx_ready, busy, frame_sent, underrun}, 0);
                tx_valid = 1'b0; tx_last = 1'b0; tx_user = 1'b0;
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            if (guard > 3000) begin
                timed_out = 1;
                break;
            end
            if (idx < n) begin
                tx_data = pl_q[idx];
                tx_last = (idx == n - 1);
                tx_user = user && tx_last;
                if (idx == drop_at && !dropped) begin
                    tx_valid = 1'b0;
                    dropped = 1;
                end else begin
                    tx_valid = 1'b1;
                end
            end
        end
        tx_valid = 1'b0; tx_last = 1'b0; tx_user = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl_a[$];
        logic [7:0] pl_b[$];
        bit to;
        int a_end, gap_rdy, en_after, len;
        bit usr;

        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end

        repeat (3) @(posedge clk);
        #1 check("reset state", {gmii_en, gmii_err, gmii_d, tx_ready, busy, frame_sent, underrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // "123456789" reference frame
        pl_q.delete();
        for (int k = 0; k < 9; k++) pl_q.push_back(8'h31 + 8'(k));
        cap.delete(); scan = 0;
        send(-1, -1, 0, to);
        check("std9 timeout", to, 0);
        repeat (90) @(posedge clk);
        #1;
        check_normal("std9", 0);
`ifndef GMII_MAC_TX_PAD_EN
        check("std9 len21", run_len, 21);
        check("std9 fcs", {cap[run_start+20].d, cap[run_start+19].d, cap[run_start+18].d, cap[run_start+17].d}, 32'hCBF43926);
`endif
        check("std9 idle", {busy, tx_ready, gmii_en}, 0);

        // Short frame (padded when built with padding)
        fill(14);
        cap.delete(); scan = 0;
        send(-1, -1, 0, to);
        check("short14 timeout", to, 0);
        repeat (90) @(posedge clk);
        #1;
        check_normal("short14", 0);
`ifdef GMII_MAC_TX_PAD_EN
        check("short14 len72", run_len, 72);
`endif

        // Back-to-back with valid held high
        fill(64); pl_a = pl_q;
        fill(64); pl_b = pl_q;
        cap.delete(); scan = 0;
        pl_q = pl_a;
        send(-1, -1, 0, to);
        check("b2b_a timeout", to, 0);
        pl_q = pl_b;
        send(-1, -1, 0, to);
        check("b2b_b timeout", to, 0);
        repeat (90) @(posedge clk);
        #1;
        pl_q = pl_a;
        check_normal("b2b_a", 0);
        a_end = run_start + run_len;
        pl_q = pl_b;
        check_normal("b2b_b", 0);
        check("b2b gap", run_start - a_end, IFG);
        gap_rdy = 0;
        for (int k = a_end; k < run_start; k++) if (cap[k].rdy) gap_rdy++;
        check("b2b gap ready", gap_rdy, 0);

        // Underrun at payload byte 20 of 100
        fill(100);
        cap.delete(); scan = 0;
        send(20, -1, 0, to);
        check("underrun timeout", to, 0);
        repeat (30) @(posedge clk);
        #1;
        build_expected();
        exp_q = exp_q[0:27];
        exp_q.push_back(8'h00);
        find_run();
        check("underrun en_len", run_len, 29);
        check("underrun bad_bytes", bad_bytes, 0);
        check("underrun err_cnt", err_cnt, 1);
        check("underrun err_last", last_rec.err, 1);
        check("underrun und_cnt", und_cnt, 1);
        check("underrun und_last", last_rec.und, 1);
        check("underrun sent_cnt", sent_cnt, 0);
        en_after = 0;
        for (int k = scan; k < cap.size(); k++) if (cap[k].en) en_after++;
        check("underrun en_after", en_after, 0);
        check("underrun idle", {busy, tx_ready}, 0);

        // Corrupt-flag frame
        fill(64);
        cap.delete(); scan = 0;
        send(-1, -1, 1, to);
        check("user timeout", to, 0);
        repeat (90) @(posedge clk);
        #1;
        check_normal("user", 1);

        // Reset mid-frame, then a clean frame
        fill(40);
        cap.delete(); scan = 0;
        send(-1, 30, 0, to);
        repeat (3) @(posedge clk);
        #1;
        check("post-reset idle", {busy, tx_ready, gmii_en}, 0);
        fill(20);
        cap.delete(); scan = 0;
        send(-1, -1, 0, to);
        check("post-reset timeout", to, 0);
        repeat (90) @(posedge clk);
        #1;
        check_normal("post-reset", 0);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, 90);
            usr = 1'($urandom_range(0, 1));
            fill(len);
            cap.delete(); scan = 0;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            send(-1, -1, usr, to);
            check($sformatf("rand%0d timeout", f), to, 0);
            repeat (90) @(posedge clk);
            #1;
            check_normal($sformatf("rand%0d len%0d", f, len), usr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gmii_mac_tx.md
# gmii_mac_tx

Byte-wide Ethernet MAC transmitter that turns a valid/ready payload stream into complete GMII frames: preamble, SFD, optional zero-padding, IEEE 802.3 FCS, and inter-frame gap. It feeds the GMII transmit inputs (`i_gmii_tx_en`/`i_gmii_tx_err`/`i_gmii_tx_d`) of `sfp_ethernet_phy_control` in the 1000Base-T path. The payload starts at the destination MAC and excludes the FCS. It runs on the PHY controller's `o_gmii_clock` domain.

## Interface
- p_IFG_BYTES, 12: minimum idle cycles (tx_en low) between frames; legal range 1..255.
- p_MIN_PAYLOAD, 60: minimum bytes before FCS when padding is compiled in; legal range 1..255.
- i_clock  in  1  GMII transmit clock, 125 MHz.
- i_reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- i_tx_data  in  8  payload byte.
- i_tx_valid  in  1  payload byte valid.
- i_tx_last  in  1  marks the final payload byte of a frame.
- i_tx_user  in  1  sampled with the last byte; 1 means corrupt the frame.
- o_tx_ready  out  1  payload byte accepted when valid && ready.
- o_gmii_tx_en  out  1  GMII TX_EN.
- o_gmii_tx_err  out  1  GMII TX_ER.
- o_gmii_tx_d  out  8  GMII TXD.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_sent  out  1  one-cycle pulse on the cycle the last FCS byte is driven.
- o_underrun  out  1  one-cycle pulse when a frame is aborted due to underrun.

## Operation
- All outputs are registered. The reset value of every output is 0, including `o_tx_ready` and `o_gmii_tx_d` = 0x00.
- States and transitions:
  - IDLE -> PREAMBLE when `i_tx_valid` = 1.
  - PREAMBLE: 7 × 0x55 -> SFD.
  - SFD: 0xD5 -> DATA.
  - DATA -> PAD when last is accepted and the byte count is below p_MIN_PAYLOAD; otherwise DATA -> FCS.
  - PAD: 0x00 bytes until the count equals p_MIN_PAYLOAD -> FCS.
  - FCS: 4 bytes -> IFG.
  - IFG: p_IFG_BYTES cycles -> IDLE.
  - DISCARD: entered on underrun; -> IFG when last is accepted.
- `o_gmii_tx_en` is 1 in PREAMBLE, SFD, DATA, PAD and FCS, and during the single abort cycle.
- `o_tx_ready` is high on the cycle the SFD is driven and on every DATA cycle until last is accepted. It is also high throughout DISCARD. It is low in all other states.
- CRC-32:
  - Reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF.
  - Covers payload and pad bytes.
  - Final value is complemented and sent least-significant byte first.
  - CRC is updated by a byte-parallel combinational function in the same cycle the byte is registered to GMII.
- Byte counter: 8 bits, saturates at 255, cleared in IDLE.
- Underrun (valid = 0 while ready = 1 in DATA):
  - Next cycle drives tx_en = 1, tx_err = 1, d = 0x00 for one cycle, and pulses `o_underrun`.
  - Then goes to DISCARD if last has not yet been accepted.
  - No FCS is sent.
- `i_tx_user` = 1 together with last: the frame completes normally, but the 4th FCS byte is driven with `o_gmii_tx_err` = 1.
- `i_tx_user` is ignored on non-last beats.
- A valid asserted during IFG is held off (ready = 0) and starts a new frame from IDLE. The frame starts exactly p_IFG_BYTES idle cycles after the last FCS byte.
- Reset asserted mid-frame: all outputs go to 0 immediately and state goes to IDLE. The truncated frame is not completed. No `o_frame_sent` or `o_underrun` pulse is generated.

## Timing
- Cycle 0: valid is seen in IDLE.
- Cycles 1–7: preamble on GMII.
- Cycle 8: SFD on GMII, ready = 1.
- A byte accepted in cycle n appears on `o_gmii_tx_d` in cycle n+1.
- The first FCS byte follows the last payload/pad byte with no gap.
- Total tx_en cycles per frame = 8 + max(N, p_MIN_PAYLOAD) + 4 with padding, or 8 + N + 4 without.
- Back-to-back throughput: 1 frame per (tx_en cycles + p_IFG_BYTES) cycles.

## Configuration
- GMII_MAC_TX_PAD_EN defined: the PAD state is present and short frames are padded with 0x00 to p_MIN_PAYLOAD before the FCS.
- GMII_MAC_TX_PAD_EN undefined: the PAD state and its compare are removed; FCS immediately follows the last payload byte for any N ≥ 1.

## Test plan
- Padding not compiled: payload "123456789" (0x31..0x39) with last on 0x39 -> GMII carries 7 × 0x55, 0xD5, 0x31..0x39, then 0x26, 0x39, 0xF4, 0xCB; tx_en high for 21 cycles; `o_frame_sent` pulses on 0xCB.
- Padding compiled: 14-byte payload -> 46 × 0x00 pad bytes follow, FCS matches the reference model over 60 bytes, tx_en high for 72 cycles.
- Two back-to-back 64-byte payloads with valid held high -> exactly 12 tx_en-low cycles between the last FCS byte of the first frame and the first 0x55 of the second; ready is low throughout the IFG.
- valid dropped at payload byte 20 of 100 -> one cycle with tx_en = 1, tx_err = 1; `o_underrun` pulses; the remaining 80 bytes are accepted with tx_en = 0; IFG follows; no FCS is sent.
- `i_tx_user` = 1 on the last byte of a 64-byte payload -> only the 4th FCS byte has tx_err = 1.
- `i_reset_n` pulled low on payload byte 30 -> all outputs are 0 in the same cycle; after release, a new frame starts cleanly with 7 × 0x55.
